// File: rtl/mesh_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mesh_buf_pkg
//  Description : Shared types and size helpers for the mesh terminal buffer
//                and its verification interface.
//  Revision    : 1.0 - initial release
// ============================================================================
package mesh_buf_pkg;

    // Packet width used across the mesh (mirrors the PAKG_SIZE define)
    localparam int c_pkg_w = 32;

    typedef logic [c_pkg_w-1:0] pkt_t;

    // Number of terminal ports on a ROWS x COLUMNS mesh (one per edge node side)
    function automatic int N_TERM(input int rows, input int columns);
        return 2 * rows + 2 * columns;
    endfunction

    // Occupancy counter width: must represent 0..DEPTH inclusive
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mesh_buf_chan.sv
`default_nettype none
// ============================================================================
//  Module      : mesh_buf_chan
//  Description : One show-ahead terminal FIFO with occupancy, full/almost-full
//                flags, sticky underflow and a saturating drop counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module mesh_buf_chan
    import mesh_buf_pkg::*;
#(
    parameter int PKG_W  = 32,
    parameter int DEPTH  = 8,
    parameter int AF_LVL = DEPTH - 2,
    parameter int DROP_W = 16,
    parameter int CW     = cnt_w(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [PKG_W-1:0]  data_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              afull_o,
    output logic              pndng_o,
    output logic [PKG_W-1:0]  data_o,
    output logic [CW-1:0]     count_o,
    output logic [DROP_W-1:0] drop_cnt_o,
    output logic              underflow_o
);

    // Pointer width; pointers wrap naturally because DEPTH is a power of two
    localparam int c_aw = $clog2(DEPTH);

    logic [PKG_W-1:0]  r_mem [DEPTH];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [DROP_W-1:0] r_drop_cnt;
    logic              r_underflow;

    logic w_empty;
    logic w_full;
    logic w_push_ok;
    logic w_pop_ok;
    logic w_drop;

    // A pop on a full FIFO frees the slot the simultaneous push needs
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_push_ok = push_i & (~w_full | pop_i);
    assign w_pop_ok  = pop_i & ~w_empty;
    assign w_drop    = push_i & ~w_push_ok;

    // Packet storage; intentionally not reset, contents are qualified by count
    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Pointers and occupancy follow accepted pushes and effective pops
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Rejected pushes counted (saturating); pop-while-empty latched until reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_drop_cnt  <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
            if (pop_i && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Flags decode from the registered count; head is zero while empty
    assign pndng_o     = ~w_empty;
    assign full_o      = w_full;
    assign afull_o     = (r_count >= CW'(AF_LVL));
    assign data_o      = w_empty ? '0 : r_mem[r_rd_ptr];
    assign count_o     = r_count;
    assign drop_cnt_o  = r_drop_cnt;
    assign underflow_o = r_underflow;

endmodule
`default_nettype wire

// File: rtl/mesh_term_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : mesh_term_buffer
//  Description : Multi-terminal ingress buffer for the mesh router. One
//                independent show-ahead FIFO per terminal port; this level
//                only maps the port arrays onto the channel instances.
//                DEPTH must be a power of two and at least 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module mesh_term_buffer
    import mesh_buf_pkg::*;
#(
    parameter  int ROWS    = 4,
    parameter  int COLUMNS = 4,
    parameter  int PKG_W   = 32,
    parameter  int DEPTH   = 8,
    parameter  int AF_LVL  = DEPTH - 2,
    parameter  int DROP_W  = 16,
    localparam int c_n     = N_TERM(ROWS, COLUMNS),
    localparam int c_cw    = cnt_w(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i      [c_n],
    input  logic [PKG_W-1:0]  data_i      [c_n],
    output logic              full_o      [c_n],
    output logic              afull_o     [c_n],
    output logic              pndng_o     [c_n],
    output logic [PKG_W-1:0]  data_o      [c_n],
    input  logic              pop_i       [c_n],
    output logic [c_cw-1:0]   count_o     [c_n],
    output logic [DROP_W-1:0] drop_cnt_o  [c_n],
    output logic              underflow_o [c_n]
);

    // Terminals share nothing but the clock and reset
    for (genvar g = 0; g < c_n; g++) begin : g_chan
        mesh_buf_chan #(
            .PKG_W  (PKG_W),
            .DEPTH  (DEPTH),
            .AF_LVL (AF_LVL),
            .DROP_W (DROP_W),
            .CW     (c_cw)
        ) u_chan (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .push_i      (push_i[g]),
            .data_i      (data_i[g]),
            .pop_i       (pop_i[g]),
            .full_o      (full_o[g]),
            .afull_o     (afull_o[g]),
            .pndng_o     (pndng_o[g]),
            .data_o      (data_o[g]),
            .count_o     (count_o[g]),
            .drop_cnt_o  (drop_cnt_o[g]),
            .underflow_o (underflow_o[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_mesh_term_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mesh_term_buffer
//  Description : Self-checking bench for mesh_term_buffer. Expected packets
//                are queued per terminal when a push is issued; a monitor
//                pops and compares whenever the mesh side consumes a head.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mesh_term_buffer;

    localparam int ROWS    = 4;
    localparam int COLUMNS = 4;
    localparam int N       = 2 * ROWS + 2 * COLUMNS;
    localparam int DEPTH   = 8;
    localparam int AF_LVL  = DEPTH - 2;
    localparam int CW      = 4;
    localparam int DROP_W  = 16;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              push  [N];
    logic [31:0]       din   [N];
    logic              pop   [N];
    logic              full  [N];
    logic              afull [N];
    logic              pndng [N];
    logic [31:0]       dout  [N];
    logic [CW-1:0]     cnt   [N];
    logic [DROP_W-1:0] drop  [N];
    logic              uf    [N];

    // Reference model: packet queue per terminal plus counters
    logic [31:0] exp_q [N][$];
    int          mcnt  [N];
    int          mdrop [N];
    bit          muf   [N];

    // Stimulus for the next cycle, consumed by step()
    bit          s_push [N];
    bit          s_pop  [N];
    logic [31:0] s_data [N];

    int total = 0;
    int bad   = 0;

    mesh_term_buffer #(
        .ROWS    (ROWS),
        .COLUMNS (COLUMNS),
        .PKG_W   (32),
        .DEPTH   (DEPTH),
        .AF_LVL  (AF_LVL),
        .DROP_W  (DROP_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (push),
        .data_i      (din),
        .full_o      (full),
        .afull_o     (afull),
        .pndng_o     (pndng),
        .data_o      (dout),
        .pop_i       (pop),
        .count_o     (cnt),
        .drop_cnt_o  (drop),
        .underflow_o (uf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s term=%0d actual=0x%0h required=0x%0h t=%0t", name, t, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int t = 0; t < N; t++) begin
            exp_q[t].delete();
            mcnt[t]  = 0;
            mdrop[t] = 0;
            muf[t]   = 1'b0;
        end
    endtask

    task automatic drive_idle();
        for (int t = 0; t < N; t++) begin
            push[t] = 1'b0;
            pop[t]  = 1'b0;
            din[t]  = '0;
            s_push[t] = 1'b0;
            s_pop[t]  = 1'b0;
            s_data[t] = '0;
        end
    endtask

    // One clock: check state left by the last edge, then apply the next stimulus
    task automatic step();
        @(posedge clk);
        #1;
        for (int t = 0; t < N; t++) begin
            chk("count", t, 32'(cnt[t]), 32'(mcnt[t]));
            chk("pndng", t, 32'(pndng[t]), 32'(mcnt[t] > 0));
            chk("full", t, 32'(full[t]), 32'(mcnt[t] == DEPTH));
            chk("afull", t, 32'(afull[t]), 32'(mcnt[t] >= AF_LVL));
            chk("drop_cnt", t, 32'(drop[t]), 32'(mdrop[t]));
            chk("underflow", t, 32'(uf[t]), 32'(muf[t]));
            chk("head", t, dout[t], (mcnt[t] > 0) ? exp_q[t][0] : 32'h0);
        end
        for (int t = 0; t < N; t++) begin
            bit acc;
            bit eff;
            push[t] = s_push[t];
            pop[t]  = s_pop[t];
            din[t]  = s_data[t];
            acc = s_push[t] && ((mcnt[t] < DEPTH) || s_pop[t]);
            eff = s_pop[t] && (mcnt[t] > 0);
            if (s_push[t] && !acc && (mdrop[t] < DROP_MAX)) mdrop[t]++;
            if (s_pop[t] && (mcnt[t] == 0)) muf[t] = 1'b1;
            if (acc) exp_q[t].push_back(s_data[t]);
            mcnt[t] = mcnt[t] + int'(acc) - int'(eff);
            s_push[t] = 1'b0;
            s_pop[t]  = 1'b0;
            s_data[t] = '0;
        end
    endtask

    // Monitor: every consumed head must be the oldest outstanding packet
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int t = 0; t < N; t++) begin
                    if (pop[t] && pndng[t]) begin
                        if (exp_q[t].size() == 0) begin
                            chk("pop_unexpected", t, dout[t], 32'hDEAD_BEEF);
                        end else begin
                            chk("pop_data", t, dout[t], exp_q[t].pop_front());
                        end
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive_idle();
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        repeat (3) step();

        // Terminal 3: fill with A0..A7, then drain in order
        for (int i = 0; i < 8; i++) begin
            s_push[3] = 1'b1;
            s_data[3] = 32'hA0 + i;
            step();
        end
        step();
        for (int i = 0; i < 8; i++) begin
            s_pop[3] = 1'b1;
            step();
        end
        step();

        // Terminal 3: fill, three dropped pushes, then push with pop while full
        for (int i = 0; i < 8; i++) begin
            s_push[3] = 1'b1;
            s_data[3] = 32'hB0 + i;
            step();
        end
        for (int i = 0; i < 3; i++) begin
            s_push[3] = 1'b1;
            s_data[3] = 32'hFF;
            step();
        end
        s_push[3] = 1'b1;
        s_pop[3]  = 1'b1;
        s_data[3] = 32'hEE;
        step();
        for (int i = 0; i < 8; i++) begin
            s_pop[3] = 1'b1;
            step();
        end
        step();

        // Terminal 5: pop on empty together with a push
        s_push[5] = 1'b1;
        s_pop[5]  = 1'b1;
        s_data[5] = 32'h55;
        step();
        step();
        s_pop[5] = 1'b1;
        step();
        step();

        // Terminal 0: pointer wrap with occupancy kept between 1 and 3
        s_push[0] = 1'b1;
        s_data[0] = 32'h100;
        step();
        for (int i = 0; i < 20; i++) begin
            if (mcnt[0] <= 1) begin
                s_push[0] = 1'b1;
                s_pop[0]  = 1'($urandom_range(0, 1));
            end else if (mcnt[0] >= 3) begin
                s_pop[0]  = 1'b1;
                s_push[0] = 1'($urandom_range(0, 1));
            end else begin
                s_push[0] = 1'($urandom_range(0, 1));
                s_pop[0]  = 1'($urandom_range(0, 1));
            end
            s_data[0] = 32'h200 + i;
            step();
        end
        while (mcnt[0] > 0) begin
            s_pop[0] = 1'b1;
            step();
        end
        step();

        // Terminal 2: five entries queued, then asynchronous reset mid-cycle
        for (int i = 0; i < 5; i++) begin
            s_push[2] = 1'b1;
            s_data[2] = 32'hC0 + i;
            step();
        end
        #2;
        rst = 1'b1;
        drive_idle();
        #1;
        for (int t = 0; t < N; t++) begin
            chk("rst_pndng", t, 32'(pndng[t]), 32'h0);
            chk("rst_count", t, 32'(cnt[t]), 32'h0);
            chk("rst_head", t, dout[t], 32'h0);
            chk("rst_full", t, 32'(full[t] | afull[t] | uf[t]), 32'h0);
        end
        clear_model();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        s_push[2] = 1'b1;
        s_data[2] = 32'h11;
        step();
        step();
        s_pop[2] = 1'b1;
        step();
        step();

        // Randomized traffic with per-window push/pop bias on every terminal
        for (int w = 0; w < 10; w++) begin
            int pp [N];
            int pq [N];
            for (int t = 0; t < N; t++) begin
                pp[t] = $urandom_range(10, 90);
                pq[t] = $urandom_range(10, 90);
            end
            for (int c = 0; c < 150; c++) begin
                for (int t = 0; t < N; t++) begin
                    s_push[t] = ($urandom_range(0, 99) < pp[t]);
                    s_pop[t]  = ($urandom_range(0, 99) < pq[t]);
                    s_data[t] = $urandom;
                end
                step();
            end
        end

        // Drain everything so every queued packet gets compared
        for (int c = 0; c < DEPTH + 2; c++) begin
            for (int t = 0; t < N; t++) s_pop[t] = 1'b1;
            step();
        end
        step();
        for (int t = 0; t < N; t++) begin
            chk("final_queue_empty", t, 32'(exp_q[t].size()), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
